// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - control/status bundle between a reset sequencer and its user
// Ports (signals):
//   sw_rst_req_i    software reset request towards the sequencer
//   ch_hold_i       per-channel hold-in-reset requests
//   rst_n_o         per-channel active-low resets from the sequencer
//   state_o         sequencer state (HOLD=0, RELEASE=1, RUN=2, SWRST=3)
//   busy_o          sequencer not in RUN
//   all_released_o  sequencer in RUN
// Modports: master drives requests and observes status; slave is the sequencer.
interface reset_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              sw_rst_req_i;
    logic [NUM_CH-1:0] ch_hold_i;
    logic [NUM_CH-1:0] rst_n_o;
    logic [1:0]        state_o;
    logic              busy_o;
    logic              all_released_o;

    modport master (
        output sw_rst_req_i,
        output ch_hold_i,
        input  rst_n_o,
        input  state_o,
        input  busy_o,
        input  all_released_o
    );

    modport slave (
        input  sw_rst_req_i,
        input  ch_hold_i,
        output rst_n_o,
        output state_o,
        output busy_o,
        output all_released_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered multi-channel reset release with software reset
// Ports:
//   clk_i      single clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   bus        reset_sequencer_if slave: sw_rst_req_i, ch_hold_i in;
//              rst_n_o, state_o, busy_o, all_released_o out
module reset_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STAGGER_CYCLES = 16,
    parameter int SW_RST_CYCLES  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    reset_sequencer_if.slave     bus
);
    localparam int IDX_W = 4;
    localparam logic [7:0]       STAG_LAST = 8'(STAGGER_CYCLES - 1);
    localparam logic [7:0]       SW_LAST   = 8'(SW_RST_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SWRST   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst_n;

    state_t            state_q, state_d;
    logic [7:0]        stag_q, stag_d;
    logic [7:0]        sw_q, sw_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] rst_n_q, rst_n_d;
    logic              hold_cur;

    // Reset deassertion synchroniser; assertion stays asynchronous.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_HOLD;
            stag_q  <= '0;
            sw_q    <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
        end else begin
            state_q <= state_d;
            stag_q  <= stag_d;
            sw_q    <= sw_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
        end
    end

    // Hold request of the channel currently waiting for release.
    always_comb begin
        hold_cur = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                hold_cur = bus.ch_hold_i[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stag_d  = stag_q;
        sw_d    = sw_q;
        idx_d   = idx_q;
        rst_n_d = '0;

        case (state_q)
            ST_HOLD: begin
                if (sync_rst_n) begin
                    state_d = ST_RELEASE;
                    stag_d  = '0;
                    idx_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (stag_q == STAG_LAST) begin
                    // Counter stays frozen at its terminal value while held.
                    if (!hold_cur) begin
                        stag_d = '0;
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_q == LAST_CH) begin
                            state_d = ST_RUN;
                        end
                    end
                end else begin
                    stag_d = stag_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (bus.sw_rst_req_i) begin
                    state_d = ST_SWRST;
                    sw_d    = '0;
                end
            end
            ST_SWRST: begin
                if (sw_q == SW_LAST) begin
                    state_d = ST_RELEASE;
                    stag_d  = '0;
                    idx_d   = '0;
                end else begin
                    sw_d = sw_q + 8'd1;
                end
            end
            default: state_d = ST_HOLD;
        endcase

        // A channel is driven from its hold input once it has been released,
        // judged on the post-edge state so the releasing edge itself raises it.
        for (int k = 0; k < NUM_CH; k++) begin
            if ((state_d == ST_RUN) ||
                ((state_d == ST_RELEASE) && (IDX_W'(k) < idx_d))) begin
                rst_n_d[k] = ~bus.ch_hold_i[k];
            end
        end
    end

    assign bus.rst_n_o        = rst_n_q;
    assign bus.state_o        = state_q;
    assign bus.busy_o         = (state_q != ST_RUN);
    assign bus.all_released_o = (state_q == ST_RUN);
endmodule
